dual_port_ram: RTL and testbench



---
 rtl/dual_port_ram.sv | 65 ++++++
 tb/tb_dual_port_ram.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// True dual-port RAM on one clock with registered, write-through read data.
// Same-address writes favour port A; a reader colliding with a writer sees the old word.
module dual_port_ram #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] datain_A,
   input  logic [ADDR_WIDTH-1:0] addr_A,
   input  logic                  wr_enA,
   input  logic                  enA,
   output logic [DATA_WIDTH-1:0] dataout_A,
   input  logic [DATA_WIDTH-1:0] datain_B,
   input  logic [ADDR_WIDTH-1:0] addr_B,
   input  logic                  wr_enB,
   input  logic                  enB,
   output logic [DATA_WIDTH-1:0] dataout_B
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [Depth];
   logic                  wr_a;
   logic                  rd_a;
   logic                  wr_b;
   logic                  rd_b;
   logic                  wr_b_store;

   always_comb begin
      wr_a       = !enA && wr_enA;
      rd_a       = !enA && !wr_enA;
      wr_b       = !enB && wr_enB;
      rd_b       = !enB && !wr_enB;
      // Port A wins a same-address double write; B's data is dropped.
      wr_b_store = wr_b && !(wr_a && (addr_A == addr_B));
   end

   // Reads sample mem before this edge's writes land, giving read-before-write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
         dataout_A <= '0;
         dataout_B <= '0;
      end else begin
         if (wr_a) begin
            mem[addr_A] <= datain_A;
            dataout_A   <= datain_A;
         end else if (rd_a) begin
            dataout_A <= mem[addr_A];
         end
         if (wr_b_store) begin
            mem[addr_B] <= datain_B;
         end
         if (wr_b) begin
            dataout_B <= datain_B;
         end else if (rd_b) begin
            dataout_B <= mem[addr_B];
         end
      end
   end

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: a behavioural model queues expected outputs per cycle,
// and each scenario task pops and compares them, alongside the fixed values from the plan.
module tb_dual_port_ram;

   localparam int AW = 5;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] datain_A = '0;
   logic [AW-1:0] addr_A = '0;
   logic          wr_enA = 1'b0;
   logic          enA = 1'b1;
   logic [DW-1:0] dataout_A;
   logic [DW-1:0] datain_B = '0;
   logic [AW-1:0] addr_B = '0;
   logic          wr_enB = 1'b0;
   logic          enB = 1'b1;
   logic [DW-1:0] dataout_B;

   int n_checks = 0;
   int n_fail = 0;

   logic [DW-1:0] model_mem [32];
   logic [DW-1:0] hold_a = '0;
   logic [DW-1:0] hold_b = '0;
   logic [DW-1:0] q_a [$];
   logic [DW-1:0] q_b [$];
   logic [DW-1:0] exp_a;
   logic [DW-1:0] exp_b;

   dual_port_ram #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .datain_A  (datain_A),
      .addr_A    (addr_A),
      .wr_enA    (wr_enA),
      .enA       (enA),
      .dataout_A (dataout_A),
      .datain_B  (datain_B),
      .addr_B    (addr_B),
      .wr_enB    (wr_enB),
      .enB       (enB),
      .dataout_B (dataout_B)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $fatal(1);
   end

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      hold_a = '0;
      hold_b = '0;
      q_a.delete();
      q_b.delete();
   endtask

   // Drive one cycle, push model expectations, then step to 1 time unit after the edge.
   task automatic drive(input logic ea, input logic wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic eb, input logic wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db);
      logic [DW-1:0] ea_val;
      logic [DW-1:0] eb_val;
      enA = ea; wr_enA = wa; addr_A = aa; datain_A = da;
      enB = eb; wr_enB = wb; addr_B = ab; datain_B = db;
      ea_val = ea ? hold_a : (wa ? da : model_mem[aa]);
      eb_val = eb ? hold_b : (wb ? db : model_mem[ab]);
      q_a.push_back(ea_val);
      q_b.push_back(eb_val);
      hold_a = ea_val;
      hold_b = eb_val;
      if (!eb && wb && !(!ea && wa && aa == ab)) model_mem[ab] = db;
      if (!ea && wa) model_mem[aa] = da;
      @(posedge clk);
      #1;
   endtask

   task automatic pop_expect();
      exp_a = q_a.pop_front();
      exp_b = q_b.pop_front();
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b1, 5'd0, 8'h5A, 1'b0, 1'b1, 5'd1, 8'hA5);
      pop_expect();
      n_checks++;
      if (dataout_A !== exp_a) begin
         n_fail++; $display("FAIL pre_reset_a: got %h expected %h", dataout_A, exp_a);
      end
      #3;
      rst_n = 1'b0;
      #1;
      model_clear();
      n_checks++;
      if (dataout_A !== 8'h00) begin
         n_fail++; $display("FAIL async_reset_a: got %h expected 00", dataout_A);
      end
      n_checks++;
      if (dataout_B !== 8'h00) begin
         n_fail++; $display("FAIL async_reset_b: got %h expected 00", dataout_B);
      end
      enA = 1'b1; enB = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (dataout_A !== 8'h00 || dataout_B !== 8'h00) begin
         n_fail++; $display("FAIL reset_held: got %h/%h expected 00/00", dataout_A, dataout_B);
      end
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd1, 8'h00);
      pop_expect();
      n_checks++;
      if (dataout_A !== exp_a || dataout_A !== 8'h00) begin
         n_fail++; $display("FAIL post_reset_rd_a: got %h expected 00", dataout_A);
      end
      n_checks++;
      if (dataout_B !== exp_b || dataout_B !== 8'h00) begin
         n_fail++; $display("FAIL post_reset_rd_b: got %h expected 00", dataout_B);
      end
   endtask

   task automatic test_fill_readback();
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, AW'(i), DW'(i), 1'b1, 1'b0, 5'd0, 8'h00);
         pop_expect();
         n_checks++;
         if (dataout_A !== exp_a) begin
            n_fail++; $display("FAIL fill_wt_a[%0d]: got %h expected %h", i, dataout_A, exp_a);
         end
      end
      drive(1'b0, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd24, 8'h00);
      pop_expect();
      n_checks++;
      if (dataout_A !== 8'h07 || dataout_A !== exp_a) begin
         n_fail++; $display("FAIL readback_a7: got %h expected 07", dataout_A);
      end
      n_checks++;
      if (dataout_B !== 8'h18 || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL readback_b24: got %h expected 18", dataout_B);
      end
   endtask

   task automatic test_disable_hold();
      drive(1'b1, 1'b1, 5'd9, 8'hFF, 1'b1, 1'b1, 5'd12, 8'hEE);
      pop_expect();
      n_checks++;
      if (dataout_A !== 8'h07 || dataout_A !== exp_a) begin
         n_fail++; $display("FAIL hold_a: got %h expected 07", dataout_A);
      end
      n_checks++;
      if (dataout_B !== 8'h18 || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL hold_b: got %h expected 18", dataout_B);
      end
      drive(1'b0, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0, 5'd12, 8'h00);
      pop_expect();
      n_checks++;
      if (dataout_A !== 8'h09 || dataout_A !== exp_a) begin
         n_fail++; $display("FAIL hold_mem_a9: got %h expected 09", dataout_A);
      end
      n_checks++;
      if (dataout_B !== 8'h0C || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL hold_mem_b12: got %h expected 0c", dataout_B);
      end
   endtask

   task automatic test_concurrent_writes();
      drive(1'b0, 1'b1, 5'd21, 8'hF0, 1'b0, 1'b1, 5'd10, 8'hF8);
      pop_expect();
      n_checks++;
      if (dataout_A !== 8'hF0 || dataout_A !== exp_a) begin
         n_fail++; $display("FAIL conc_wt_a: got %h expected f0", dataout_A);
      end
      n_checks++;
      if (dataout_B !== 8'hF8 || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL conc_wt_b: got %h expected f8", dataout_B);
      end
      drive(1'b0, 1'b0, 5'd10, 8'h00, 1'b0, 1'b0, 5'd21, 8'h00);
      pop_expect();
      n_checks++;
      if (dataout_A !== 8'hF8 || dataout_A !== exp_a) begin
         n_fail++; $display("FAIL conc_rd_a10: got %h expected f8", dataout_A);
      end
      n_checks++;
      if (dataout_B !== 8'hF0 || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL conc_rd_b21: got %h expected f0", dataout_B);
      end
   endtask

   task automatic test_collisions();
      drive(1'b0, 1'b1, 5'd3, 8'hAA, 1'b0, 1'b1, 5'd3, 8'h55);
      pop_expect();
      n_checks++;
      if (dataout_A !== 8'hAA || dataout_B !== 8'h55) begin
         n_fail++; $display("FAIL ww_wt: got %h/%h expected aa/55", dataout_A, dataout_B);
      end
      drive(1'b0, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd3, 8'h00);
      pop_expect();
      n_checks++;
      if (dataout_A !== 8'hAA || dataout_A !== exp_a) begin
         n_fail++; $display("FAIL ww_rd_a3: got %h expected aa", dataout_A);
      end
      n_checks++;
      if (dataout_B !== 8'hAA || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL ww_rd_b3: got %h expected aa", dataout_B);
      end
      drive(1'b0, 1'b1, 5'd4, 8'h11, 1'b0, 1'b0, 5'd4, 8'h00);
      pop_expect();
      n_checks++;
      if (dataout_B !== 8'h04 || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL rw_old_b4: got %h expected 04", dataout_B);
      end
      n_checks++;
      if (dataout_A !== 8'h11 || dataout_A !== exp_a) begin
         n_fail++; $display("FAIL rw_wt_a4: got %h expected 11", dataout_A);
      end
      drive(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd4, 8'h00);
      pop_expect();
      n_checks++;
      if (dataout_B !== 8'h11 || dataout_B !== exp_b) begin
         n_fail++; $display("FAIL rw_new_b4: got %h expected 11", dataout_B);
      end
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, AW'(i + 8), 8'hC0 + DW'(i), 1'b0, 1'b1, AW'(i + 16), 8'h30 + DW'(i));
         pop_expect();
         n_checks++;
         if (dataout_A !== exp_a || dataout_B !== exp_b) begin
            n_fail++; $display("FAIL burst_wt[%0d]: got %h/%h expected %h/%h",
                               i, dataout_A, dataout_B, exp_a, exp_b);
         end
      end
      // Next write is already presented when reset hits, so it must be aborted.
      enA = 1'b0; wr_enA = 1'b1; addr_A = 5'd30; datain_A = 8'h77;
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      n_checks++;
      if (dataout_A !== 8'h00 || dataout_B !== 8'h00) begin
         n_fail++; $display("FAIL mid_reset_out: got %h/%h expected 00/00", dataout_A, dataout_B);
      end
      @(posedge clk);
      #2;
      enA = 1'b1; enB = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, AW'(i), 8'h00, 1'b0, 1'b0, AW'(31 - i), 8'h00);
         pop_expect();
         n_checks++;
         if (dataout_A !== 8'h00 || dataout_A !== exp_a) begin
            n_fail++; $display("FAIL cleared_a[%0d]: got %h expected 00", i, dataout_A);
         end
         n_checks++;
         if (dataout_B !== 8'h00 || dataout_B !== exp_b) begin
            n_fail++; $display("FAIL cleared_b[%0d]: got %h expected 00", 31 - i, dataout_B);
         end
      end
   endtask

   initial begin
      model_clear();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_fill_readback();
      test_disable_hold();
      test_concurrent_writes();
      test_collisions();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
